i2s_audio_tx: RTL and testbench
===============================

Name: i2s_audio_tx

Overview:
- Consumer end of the sample interface driven by the DDS voice generators and mixer: accepts stereo 16-bit offset-binary samples (0x8000 = silence) and serialises them as a standard I2S stream (BCLK, LRCLK, SDATA) for an external audio DAC.
- Converts offset-binary to two's complement.
- Buffers one stereo frame behind a valid/ready handshake.
- Derives all I2S timing from the system clock.

Parameters:
- BCLK_HALF_DIV, 32, clk cycles per BCLK half-period; legal range is 2 or more. The audio sample rate is clk / (2*BCLK_HALF_DIV*32).

Ports:
- clk  in  1  system clock
- rst_active_high  in  1  reset, synchronous, active-high
- sample_l  in  16  left sample, offset-binary
- sample_r  in  16  right sample, offset-binary
- sample_valid  in  1  sample_l/sample_r hold a frame
- sample_ready  out  1  holding register is empty; a frame is accepted when valid and ready are both high
- i2s_bclk  out  1  bit clock, registered
- i2s_lrclk  out  1  word select: 0 = left, 1 = right; registered
- i2s_sdata  out  1  serial data, MSB first, registered
- frame_strobe  out  1  one-cycle pulse when a frame is loaded into the shifter
- underrun  out  1  one-cycle pulse when a frame is loaded while the holding register is empty

Behaviour:
- Reset, synchronous, active-high, from any state:
  - Outputs: i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, frame_strobe=0, underrun=0, sample_ready=0 while reset is asserted.
  - Internal state: div_cnt=0, slot=0, holding register empty, last-frame register = 32'h0000_0000 (two's-complement silence), shift register = 0.
  - Reset mid-frame abandons the frame immediately; there is no completion.
- Divider:
  - div_cnt counts 0..BCLK_HALF_DIV-1 and wraps.
  - On the cycle div_cnt==BCLK_HALF_DIV-1, i2s_bclk toggles at the next edge.
  - After reset, the first toggle is a rising edge, at clk edge BCLK_HALF_DIV after reset deasserts.
- Slot counter:
  - 5-bit slot, 0..31, wraps.
  - Advances only on a BCLK falling toggle.
  - i2s_lrclk, i2s_sdata and the slot all update on the same clk edge as that falling toggle. Data therefore changes on the BCLK falling edge and is stable at the rising edge.
- LRCLK: after the slot update, i2s_lrclk = 1 when the new slot is in 16..31, else 0.
- I2S one-bit delay:
  - The MSB of the left word appears in slot 1.
  - Slot 0 carries the LSB of the previous frame's right word.
- Frame load, on the falling toggle where slot goes from 0 to 1:
  - Source frame is {tc(L), tc(R)}, where tc(x) = {~x[15], x[14:0]}.
  - If the holding register is full: the shifter loads the holding register, last-frame is updated, and the holding register becomes empty.
  - If the holding register is empty: the shifter reloads last-frame (the previous frame repeats) and underrun pulses.
  - frame_strobe pulses on every load, on the same cycle as the load.
  - i2s_sdata = bit 31 of the loaded word.
  - On each subsequent falling toggle, the shifter shifts left and i2s_sdata = new bit 31.
- Handshake:
  - sample_ready = ~holding_full when not in reset.
  - Acceptance stores tc-converted samples.
  - sample_valid with sample_ready low is ignored; the source must hold its data until ready.
- Same-cycle accept and load:
  - The load sees the pre-edge holding state.
  - If the holding register was empty: underrun pulses, last-frame repeats, and the newly accepted frame is stored for the next frame.
  - If the holding register was full: ready was 0, so no accept can occur in that cycle.
- No combinational path from sample_valid to any output.

Decomposition:
- audio_pkg holds:
  - SAMPLE_W=16
  - FRAME_SLOTS=32
  - typedef stereo_frame_t as a packed struct {l, r}
  - function ob_to_tc
- Sub-module i2s_clk_gen: divider plus slot counter. Outputs bclk, lrclk_next, fall_tick, slot, frame_start.

Test Plan:
1. Reset, BCLK_HALF_DIV=2: deassert reset → all outputs 0 and sample_ready=1; bclk rises at cycle 2 and falls at cycle 4; frame_strobe and underrun pulse at cycle 4 with sdata=0.
2. Single frame: accept L=16'h9234, R=16'h0000 before the first load → slots 1-16 carry 16'h1234 MSB-first with lrclk=0 in slots 1-15; slots 17-31 plus the next slot 0 carry 16'h8000 with lrclk=1 in slots 16-31; underrun stays 0.
3. Underrun: stop sample_valid after one frame → the next frame repeats identical bits, and underrun and frame_strobe pulse together exactly once per frame.
4. Backpressure: hold sample_valid high with frames A, B → A is accepted at once and sample_ready drops; B waits until A's load cycle +1; output order is A then B with no drop or duplicate.
5. Simultaneous event: assert sample_valid first in the exact load cycle with the holding register empty → underrun=1, the previous frame is sent, and the new frame goes out in the following frame.
6. Mid-frame reset: assert reset at slot 9 for one cycle → all outputs are 0 next cycle and the timing restarts as in test 1.

Source files
------------

// File: rtl/audio_pkg.sv
// =============================================================================
// Module   : audio_pkg
// Purpose  : Shared widths, stereo frame type and sample-format helper.
// Revision : 1.0
// =============================================================================
`default_nettype none

package audio_pkg;
  localparam int SAMPLE_W    = 16;
  localparam int FRAME_SLOTS = 32;
  localparam int FRAME_W     = 2 * SAMPLE_W;
  localparam int SLOT_W      = $clog2(FRAME_SLOTS);

  typedef struct packed {
    logic [SAMPLE_W-1:0] l;
    logic [SAMPLE_W-1:0] r;
  } stereo_frame_t;

  // Offset-binary to two's complement: flipping the MSB maps 0x8000 to zero.
  function automatic logic [SAMPLE_W-1:0] ob_to_tc(input logic [SAMPLE_W-1:0] x);
    return {~x[SAMPLE_W-1], x[SAMPLE_W-2:0]};
  endfunction
endpackage

`default_nettype wire

// File: rtl/i2s_audio_tx_if.sv
// =============================================================================
// Module   : i2s_audio_tx_if
// Purpose  : Stereo sample valid/ready channel from the mixer to the I2S sender.
// Revision : 1.0
// =============================================================================
`default_nettype none

interface i2s_audio_tx_if;
  import audio_pkg::*;

  logic [SAMPLE_W-1:0] sample_l;
  logic [SAMPLE_W-1:0] sample_r;
  logic                sample_valid;
  logic                sample_ready;

  modport master (output sample_l, output sample_r, output sample_valid, input sample_ready);
  modport slave  (input sample_l, input sample_r, input sample_valid, output sample_ready);
endinterface

`default_nettype wire

// File: rtl/i2s_clk_gen.sv
// =============================================================================
// Module   : i2s_clk_gen
// Purpose  : BCLK divider and 32-slot counter that drive all I2S timing.
// Revision : 1.0
// =============================================================================
`default_nettype none

module i2s_clk_gen
  import audio_pkg::*;
#(
  parameter int BCLK_HALF_DIV = 32
) (
  input  logic              clk,
  input  logic              rst_active_high,
  output logic              bclk_o,
  output logic              lrclk_next_o,
  output logic              fall_tick_o,
  output logic [SLOT_W-1:0] slot_o,
  output logic              frame_start_o
);
  localparam int              DIV_W   = (BCLK_HALF_DIV > 2) ? $clog2(BCLK_HALF_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCLK_HALF_DIV - 1);

  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              bclk_q, bclk_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [SLOT_W-1:0] slot_inc;
  logic              half_tick;

  assign half_tick     = (div_cnt_q == DIV_MAX);
  assign fall_tick_o   = half_tick & bclk_q;
  assign slot_inc      = slot_q + SLOT_W'(1);
  // Upper half of the 32-slot frame is the right channel.
  assign lrclk_next_o  = slot_inc[SLOT_W-1];
  assign frame_start_o = fall_tick_o & (slot_q == '0);
  assign bclk_o        = bclk_q;
  assign slot_o        = slot_q;

  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    bclk_d    = bclk_q;
    slot_d    = slot_q;
    if (half_tick) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end
    if (fall_tick_o) begin
      slot_d = slot_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_active_high) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      slot_q    <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      slot_q    <= slot_d;
    end
  end
endmodule

`default_nettype wire

// File: rtl/i2s_audio_tx.sv
// =============================================================================
// Module   : i2s_audio_tx
// Purpose  : Buffers one stereo frame and serialises it as an I2S stream.
// Revision : 1.0
// =============================================================================
`default_nettype none

module i2s_audio_tx
  import audio_pkg::*;
#(
  parameter int BCLK_HALF_DIV = 32
) (
  input  logic                 clk,
  input  logic                 rst_active_high,
  i2s_audio_tx_if.slave        sample_if,
  output logic                 i2s_bclk,
  output logic                 i2s_lrclk,
  output logic                 i2s_sdata,
  output logic                 frame_strobe,
  output logic                 underrun
);
  logic              lrclk_next;
  logic              fall_tick;
  logic              frame_start;
  logic [SLOT_W-1:0] slot;

  stereo_frame_t     hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [FRAME_W-1:0] last_q, last_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic              lrclk_q, lrclk_d;
  logic              sdata_q, sdata_d;
  logic              strobe_q, strobe_d;
  logic              underrun_q, underrun_d;
  logic              accept;

  i2s_clk_gen #(
    .BCLK_HALF_DIV (BCLK_HALF_DIV)
  ) u_clk_gen (
    .clk             (clk),
    .rst_active_high (rst_active_high),
    .bclk_o          (i2s_bclk),
    .lrclk_next_o    (lrclk_next),
    .fall_tick_o     (fall_tick),
    .slot_o          (slot),
    .frame_start_o   (frame_start)
  );

  assign sample_if.sample_ready = ~rst_active_high & ~hold_full_q;
  assign accept                 = sample_if.sample_valid & ~hold_full_q;

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    last_d      = last_q;
    shift_d     = shift_q;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    strobe_d    = 1'b0;
    underrun_d  = 1'b0;

    if (fall_tick) begin
      lrclk_d = lrclk_next;
      if (frame_start) begin
        strobe_d = 1'b1;
        // Load decision uses the pre-edge holding state, so a same-cycle accept
        // is kept for the next frame while the previous frame repeats.
        if (hold_full_q) begin
          shift_d     = hold_q;
          last_d      = hold_q;
          hold_full_d = 1'b0;
        end else begin
          shift_d    = last_q;
          underrun_d = 1'b1;
        end
      end else begin
        shift_d = {shift_q[FRAME_W-2:0], 1'b0};
      end
      sdata_d = shift_d[FRAME_W-1];
    end

    if (accept) begin
      hold_d.l    = ob_to_tc(sample_if.sample_l);
      hold_d.r    = ob_to_tc(sample_if.sample_r);
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_active_high) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      last_q      <= '0;
      shift_q     <= '0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      strobe_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      last_q      <= last_d;
      shift_q     <= shift_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      strobe_q    <= strobe_d;
      underrun_q  <= underrun_d;
    end
  end

  assign i2s_lrclk    = lrclk_q;
  assign i2s_sdata    = sdata_q;
  assign frame_strobe = strobe_q;
  assign underrun     = underrun_q;

  logic unused_slot;
  assign unused_slot = ^slot;
endmodule

`default_nettype wire

// File: tb/tb_i2s_audio_tx.sv
// =============================================================================
// Module   : tb_i2s_audio_tx
// Purpose  : Scoreboard bench: an I2S receiver model rebuilds each frame.
// Revision : 1.0
// =============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_i2s_audio_tx;
  import audio_pkg::*;

  localparam int HALF       = 2;
  localparam int FIRST_LOAD = 2 * HALF;
  localparam int FRAME_CYC  = 2 * HALF * FRAME_SLOTS;
  localparam int BUDGET     = 3 * FRAME_CYC;

  logic clk = 1'b0;
  logic rst_active_high = 1'b1;
  logic i2s_bclk, i2s_lrclk, i2s_sdata, frame_strobe, underrun;

  i2s_audio_tx_if sif ();

  i2s_audio_tx #(.BCLK_HALF_DIV(HALF)) dut (
    .clk             (clk),
    .rst_active_high (rst_active_high),
    .sample_if       (sif),
    .i2s_bclk        (i2s_bclk),
    .i2s_lrclk       (i2s_lrclk),
    .i2s_sdata       (i2s_sdata),
    .frame_strobe    (frame_strobe),
    .underrun        (underrun)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] word; logic ur; } exp_t;
  typedef struct { logic [31:0] word; logic ur; int stray; bit lr_ok; } got_t;

  exp_t exp_q[$];
  got_t got_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  // cyc equals the number of clk edges since reset was last sampled high.
  always @(posedge clk) begin
    if (rst_active_high) cyc <= 0;
    else                 cyc <= cyc + 1;
  end

  // Independent I2S receiver: a frame is the 32 BCLK rising edges after a strobe.
  logic        prev_bclk = 1'b0;
  bit          cap_on = 1'b0;
  int          nbits = 0;
  logic [31:0] cap_word = '0;
  logic        cap_ur = 1'b0;
  int          cap_stray = 0;
  bit          cap_lr = 1'b1;

  always @(negedge clk) begin
    if (rst_active_high) begin
      cap_on    = 1'b0;
      prev_bclk = 1'b0;
    end else begin
      if (underrun && !frame_strobe) cap_stray = cap_stray + 1;
      if (frame_strobe) begin
        cap_on = 1'b1; nbits = 0; cap_word = '0; cap_ur = underrun; cap_stray = 0; cap_lr = 1'b1;
      end else if (cap_on && i2s_bclk && !prev_bclk) begin
        nbits    = nbits + 1;
        cap_word = {cap_word[30:0], i2s_sdata};
        if (i2s_lrclk !== ((nbits >= 16 && nbits <= 31) ? 1'b1 : 1'b0)) cap_lr = 1'b0;
        if (nbits == 32) begin
          got_q.push_back('{word: cap_word, ur: cap_ur, stray: cap_stray, lr_ok: cap_lr});
          cap_on = 1'b0;
        end
      end
      prev_bclk = i2s_bclk;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_active_high  = 1'b1;
    sif.sample_valid = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    got_q.delete();
    rst_active_high = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after acceptance with valid still high.
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, output int acc);
    bit done = 1'b0;
    sif.sample_l     = l;
    sif.sample_r     = r;
    sif.sample_valid = 1'b1;
    acc = -1;
    for (int n = 0; n < BUDGET && !done; n++) begin
      #1;
      if (sif.sample_ready === 1'b1) begin
        acc  = cyc + 1;
        done = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_got(output got_t g, output bit ok);
    ok = 1'b0;
    g  = '{word: '0, ur: 1'b0, stray: 0, lr_ok: 1'b0};
    for (int n = 0; n < BUDGET && !ok; n++) begin
      if (got_q.size() > 0) begin
        g  = got_q.pop_front();
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_cyc(input int target);
    for (int n = 0; n < BUDGET && cyc != target; n++) @(negedge clk);
  endtask

  task automatic test_reset();
    logic eb, ep;
    @(negedge clk);
    rst_active_high  = 1'b1;
    sif.sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({i2s_bclk, i2s_lrclk, i2s_sdata, frame_strobe, underrun, sif.sample_ready} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b, want 000000",
               {i2s_bclk, i2s_lrclk, i2s_sdata, frame_strobe, underrun, sif.sample_ready});
    end
    rst_active_high = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      eb = (k == 2 || k == 3 || k == 6);
      ep = (k == 4);
      checks++;
      if ({i2s_bclk, frame_strobe, underrun, i2s_sdata, i2s_lrclk, sif.sample_ready} !== {eb, ep, ep, 3'b001}) begin
        fails++;
        $display("FAIL reset_timing cycle %0d: got bclk/strb/ur/sd/lr/rdy=%b, want %b", k,
                 {i2s_bclk, frame_strobe, underrun, i2s_sdata, i2s_lrclk, sif.sample_ready},
                 {eb, ep, ep, 3'b001});
      end
    end
  endtask

  task automatic test_single_frame();
    int acc; got_t g; bit ok; exp_t e;
    do_reset();
    send_frame(16'h9234, 16'h0000, acc);
    sif.sample_valid = 1'b0;
    checks++;
    if (acc != 1) begin fails++; $display("FAIL single_accept: got cycle %0d, want 1", acc); end
    exp_q.push_back('{word: 32'h1234_8000, ur: 1'b0});
    exp_q.push_back('{word: 32'h1234_8000, ur: 1'b1});
    exp_q.push_back('{word: 32'h1234_8000, ur: 1'b1});
    for (int i = 0; i < 3; i++) begin
      wait_got(g, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || g.word !== e.word || g.ur !== e.ur || g.stray != 0 || !g.lr_ok) begin
        fails++;
        $display("FAIL single_underrun frame %0d: got ok=%b word=%h ur=%b stray=%0d lr_ok=%b, want word=%h ur=%b stray=0 lr_ok=1",
                 i, ok, g.word, g.ur, g.stray, g.lr_ok, e.word, e.ur);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc_a, acc_b; got_t g; bit ok; exp_t e;
    do_reset();
    send_frame(16'hA5A5, 16'h5A5A, acc_a);
    #1;
    checks++;
    if (acc_a != 1 || sif.sample_ready !== 1'b0) begin
      fails++;
      $display("FAIL bp_accept_a: got cycle %0d ready=%b, want 1 ready=0", acc_a, sif.sample_ready);
    end
    send_frame(16'h0123, 16'hFEDC, acc_b);
    sif.sample_valid = 1'b0;
    checks++;
    if (acc_b != FIRST_LOAD + 1) begin
      fails++; $display("FAIL bp_accept_b: got cycle %0d, want %0d", acc_b, FIRST_LOAD + 1);
    end
    exp_q.push_back('{word: 32'h25A5_DA5A, ur: 1'b0});
    exp_q.push_back('{word: 32'h8123_7EDC, ur: 1'b0});
    exp_q.push_back('{word: 32'h8123_7EDC, ur: 1'b1});
    for (int i = 0; i < 3; i++) begin
      wait_got(g, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || g.word !== e.word || g.ur !== e.ur || g.stray != 0 || !g.lr_ok) begin
        fails++;
        $display("FAIL backpressure frame %0d: got ok=%b word=%h ur=%b stray=%0d lr_ok=%b, want word=%h ur=%b",
                 i, ok, g.word, g.ur, g.stray, g.lr_ok, e.word, e.ur);
      end
    end
  endtask

  task automatic test_simultaneous();
    int acc; got_t g; bit ok; exp_t e;
    do_reset();
    send_frame(16'hC001, 16'h3FFE, acc);
    sif.sample_valid = 1'b0;
    exp_q.push_back('{word: 32'h4001_BFFE, ur: 1'b0});
    exp_q.push_back('{word: 32'h4001_BFFE, ur: 1'b1});
    exp_q.push_back('{word: 32'h0765_C321, ur: 1'b0});
    wait_cyc(FIRST_LOAD + FRAME_CYC - 1);
    send_frame(16'h8765, 16'h4321, acc);
    sif.sample_valid = 1'b0;
    checks++;
    if (acc != FIRST_LOAD + FRAME_CYC) begin
      fails++; $display("FAIL simul_accept: got cycle %0d, want %0d", acc, FIRST_LOAD + FRAME_CYC);
    end
    for (int i = 0; i < 3; i++) begin
      wait_got(g, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || g.word !== e.word || g.ur !== e.ur || g.stray != 0 || !g.lr_ok) begin
        fails++;
        $display("FAIL simultaneous frame %0d: got ok=%b word=%h ur=%b stray=%0d lr_ok=%b, want word=%h ur=%b",
                 i, ok, g.word, g.ur, g.stray, g.lr_ok, e.word, e.ur);
      end
    end
  endtask

  task automatic test_midframe_reset();
    int acc; logic eb, ep;
    do_reset();
    send_frame(16'h7FFF, 16'h8000, acc);
    sif.sample_valid = 1'b0;
    // Slot 9 spans cycles 36..39; cycle 38 is its BCLK-high half.
    wait_cyc(FIRST_LOAD + 8 * 2 * HALF + HALF);
    checks++;
    if ({i2s_bclk, i2s_sdata, i2s_lrclk} !== 3'b110) begin
      fails++; $display("FAIL mid_pre_reset: got bclk/sd/lr=%b, want 110", {i2s_bclk, i2s_sdata, i2s_lrclk});
    end
    rst_active_high = 1'b1;
    @(negedge clk);
    checks++;
    if ({i2s_bclk, i2s_lrclk, i2s_sdata, frame_strobe, underrun, sif.sample_ready} !== 6'b0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got %b, want 000000",
               {i2s_bclk, i2s_lrclk, i2s_sdata, frame_strobe, underrun, sif.sample_ready});
    end
    rst_active_high = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      eb = (k == 2 || k == 3 || k == 6);
      ep = (k == 4);
      checks++;
      if ({i2s_bclk, frame_strobe, underrun, i2s_sdata, i2s_lrclk, sif.sample_ready} !== {eb, ep, ep, 3'b001}) begin
        fails++;
        $display("FAIL mid_restart cycle %0d: got bclk/strb/ur/sd/lr/rdy=%b, want %b", k,
                 {i2s_bclk, frame_strobe, underrun, i2s_sdata, i2s_lrclk, sif.sample_ready},
                 {eb, ep, ep, 3'b001});
      end
    end
  endtask

  initial begin
    sif.sample_valid = 1'b0;
    sif.sample_l     = 16'h8000;
    sif.sample_r     = 16'h8000;
    test_reset();
    test_single_frame();
    test_backpressure();
    test_simultaneous();
    test_midframe_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, fails);
    $fatal(1);
  end
endmodule

`default_nettype wire
